// File: rtl/julia_pixel_writer.sv
// rtl/julia_pixel_writer.sv - round-robin pixel arbiter feeding a buffered Avalon-MM write master
// One engine is granted per cycle into a DEPTH-entry FIFO; the head entry is driven onto the write port.
module julia_pixel_writer #(
    parameter int NUM_JULIA = 16,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W*NUM_JULIA-1:0]    cataddresses,
    input  logic [DATA_W*NUM_JULIA-1:0]    catpixels,
    input  logic [NUM_JULIA-1:0]           done,
    output logic [NUM_JULIA-1:0]           free,
    input  logic                           wait_request,
    output logic [ADDR_W-1:0]              write_address,
    output logic [DATA_W-1:0]              write_data,
    output logic                           write_enable,
    output logic [$clog2(DEPTH+1)-1:0]     fill_level,
    output logic [31:0]                    write_count
);
    localparam int IDX_W = $clog2(NUM_JULIA);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [NUM_JULIA-1:0] elig;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     rr_next;
    logic                 grant_found;
    logic                 push;
    logic                 pop;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_pixel;
    logic [ENT_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [ENT_W-1:0]     head;

    // An engine whose free pulse is out this cycle still shows done; mask it so it is not granted twice.
    assign elig = done & ~free;

    always_comb begin
        int j;
        logic [IDX_W-1:0] idx;
        j           = 0;
        idx         = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_JULIA; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_JULIA) begin
                j = j - NUM_JULIA;
            end
            idx = IDX_W'(j);
            if (!grant_found && elig[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_pixel = '0;
        for (int i = 0; i < NUM_JULIA; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                sel_addr  = cataddresses[i*ADDR_W +: ADDR_W];
                sel_pixel = catpixels[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_next = (grant_idx == IDX_W'(NUM_JULIA - 1)) ? '0 : grant_idx + 1'b1;

    // Fullness is judged on the registered level, so a same-cycle pop never opens a slot early.
    assign push = grant_found && (fill_level < CNT_W'(DEPTH));
    assign pop  = write_enable && !wait_request;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            free        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_level  <= '0;
            write_count <= '0;
        end else begin
            free <= '0;
            if (push) begin
                free   <= NUM_JULIA'(1) << grant_idx;
                rr_ptr <= rr_next;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                write_count <= write_count + 32'd1;
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sel_addr, sel_pixel};
        end
    end

    assign head          = mem[rd_ptr];
    assign write_enable  = (fill_level != '0);
    assign write_address = write_enable ? head[ENT_W-1:DATA_W] : '0;
    assign write_data    = write_enable ? head[DATA_W-1:0] : '0;

endmodule

// File: doc/julia_pixel_writer.md
# julia_pixel_writer

Parametrised pixel write-back controller between the array of NUM_JULIA Julia-set compute engines and the Avalon-MM frame-buffer write port. Each cycle a round-robin arbiter grants one engine with a finished pixel, copies its address/pixel into a DEPTH-entry write FIFO and pulses that engine's free line. An independent write master drains the FIFO, honouring wait_request. Unlike the single-outstanding, fixed-priority controller it supersedes, it buffers several pixels, accepts one per cycle and arbitrates fairly.

## Interface
- NUM_JULIA, 16, number of compute engines (≥2)
- ADDR_W, 32, write address width
- DATA_W, 32, pixel data width
- DEPTH, 4, write FIFO entries (power of two, ≥2)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cataddresses  in  ADDR_W*NUM_JULIA  concatenated engine addresses; engine i at [ADDR_W*i +: ADDR_W]
- catpixels  in  DATA_W*NUM_JULIA  concatenated engine pixels, same packing
- done  in  NUM_JULIA  engine i holds a valid pixel; held until free[i] seen
- free  out  NUM_JULIA  one-cycle, one-hot pulse: engine i's pixel captured
- wait_request  in  1  Avalon slave stall
- write_address  out  ADDR_W  FIFO head address, 0 when FIFO empty
- write_data  out  DATA_W  FIFO head pixel, 0 when FIFO empty
- write_enable  out  1  FIFO not empty
- fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy
- write_count  out  32  completed writes, wraps 2^32-1 → 0

## Operation
- Eligible vector: elig = done & ~free (engine being released this cycle is never re-granted while its done falls).
- Grant allowed only when fill_level < DEPTH (no grant when full, even if a pop occurs the same cycle).
- Round-robin: rr_ptr (0..NUM_JULIA-1) marks highest-priority engine; grant g = first set bit of elig scanning rr_ptr, rr_ptr+1, …, wrapping past NUM_JULIA-1 to 0.
- On grant at edge: free <= one-hot(g); FIFO push {cataddresses[g], catpixels[g]}; rr_ptr <= (g+1) mod NUM_JULIA. No grant: free <= 0, rr_ptr unchanged.
- Write master: write_enable = (fill_level != 0); address/data from head entry, stable while wait_request high. Pop on edge where write_enable & ~wait_request; write_count increments on each pop.
- Simultaneous push and pop: both happen, fill_level unchanged. Push into empty FIFO: entry visible next cycle, never same cycle.
- FIFO: circular, wr/rd pointers $clog2(DEPTH) bits wrapping naturally; order strictly preserved.
- Reset (any time, incl. mid-write with wait_request high): FIFO emptied, pointers 0, rr_ptr 0, free 0, write_enable/address/data 0, fill_level 0, write_count 0. Buffered pixels are discarded; engines still holding done are re-granted after reset.

## Timing
- done[i] sampled at edge N with FIFO not full and i winning → free[i] high cycle N+1 only; write_enable high cycle N+1 if FIFO was empty.
- Throughput: one grant per cycle, one write per cycle with wait_request low.
- Engine requirement: done[i] deasserts within one cycle of seeing free[i]; the ~free mask covers exactly that cycle.
- Reset values: free 0, write_enable 0, write_address 0, write_data 0, fill_level 0, write_count 0.
- fill_level and write_count registered; write_* outputs combinational from registered FIFO state only (no path from inputs).

## Test plan
- Single request: done[3]=1, addr 0x100, pixel 0xABCD, wait_request 0 → free=0x0008 one cycle, next cycle write_enable=1, addr 0x100, data 0xABCD; write_count=1.
- All 16 done together, wait_request 0 → free pulses engines 0,1,…,15 in order on consecutive cycles; 16 writes in same order.
- wait_request held 1, 6 engines done → exactly 4 grants, fill_level=4, no free while full; release wait_request → remaining 2 granted as slots free, 6 writes in grant order.
- Wrap: rr_ptr=15 after grant of 14, done[15] and done[0] set → 15 granted first, then 0.
- Stall hold: wait_request 1 for 5 cycles with head 0x200/0x55 → outputs stable all 5 cycles, pop only after wait_request low.
- Reset asserted with fill_level=3 and wait_request 1 → all outputs 0 immediately; after deassert, pending done engines re-granted starting from engine 0.
